req_gnt_arbiter: RTL

Round-robin arbiter that shares one busy-signalling resource among N_REQ requesters. It uses the req/gnt/busy handshake the assertion layer checks. It grants one requester at a time, holds the grant while the resource reports busy, and reclaims the grant when the transfer ends, the requester withdraws, or the resource never acknowledges. It sits between the requester ports and the shared resource.

---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 32 +++
 rtl/req_gnt_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM encoding and limits for the arbiter family.
// Also carries a small modular index helper used by pickers.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int ACK_WAIT_DEF = 4;
  localparam int N_REQ_DEF    = 4;
  localparam int N_REQ_MAX    = 16;

  function automatic int wrap_add(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Finds the first set req bit at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = N_REQ_DEF
)(
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] pick,
  output logic                 any
);

  localparam int W = $clog2(N);

  logic [N-1:0] rot;
  int           off;

  assign rot = N'({req, req} >> ptr);
  assign any = |req;

  // Lowest set bit of the rotated request, mapped back to an index
  always_comb begin
    off  = 0;
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pick = W'(wrap_add(int'(ptr), off, N));
  end

endmodule

// File: rtl/req_gnt_arbiter.sv
// req_gnt_arbiter: round-robin owner of one shared busy resource.
// Grants one requester, holds while busy, reclaims on end/withdraw/no-ack.
module req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ACK_WAIT = ACK_WAIT_DEF
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     busy,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid,
  output logic                     err_noack
);

  localparam int W  = $clog2(N_REQ);
  localparam int CW = $clog2(ACK_WAIT + 1);

  arb_state_e       state;
  logic [W-1:0]     ptr;
  logic [W-1:0]     pick;
  logic             any;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             timeout;
  logic             withdraw;
  logic [N_REQ-1:0] pick_oh;
  logic [W-1:0]     ptr_nxt;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  assign gnt_valid = |gnt;

  // Saturating wait step, exit conditions and next pointer
  always_comb begin
    cnt_inc  = cnt;
    if (cnt != CW'(ACK_WAIT)) begin
      cnt_inc = cnt + CW'(1);
    end
    timeout  = (cnt_inc == CW'(ACK_WAIT));
    withdraw = ~|(req & gnt);
    pick_oh  = N_REQ'(1) << pick;
    ptr_nxt  = gnt_id + W'(1);
    if (gnt_id == W'(N_REQ - 1)) begin
      ptr_nxt = '0;
    end
  end

  // Grant FSM with registered grant, id, pointer and no-ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      ptr       <= '0;
      cnt       <= '0;
      err_noack <= 1'b0;
    end else begin
      err_noack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any && !busy) begin
            gnt    <= pick_oh;
            gnt_id <= pick;
            cnt    <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          cnt <= cnt_inc;
          if (busy) begin
            state <= BUSY;
          end else if (withdraw) begin
            gnt   <= '0;
            state <= RELEASE;
          end else if (timeout) begin
            gnt       <= '0;
            err_noack <= 1'b1;
            state     <= RELEASE;
          end
        end
        BUSY: begin
          if (!busy) begin
            gnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          ptr <= ptr_nxt;
          if (!busy) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
